// File: rtl/reorder_buffer_pkg.sv
// reorder_buffer_pkg: shared widths, the ROB entry type and small helpers.
// The physical register count is fixed here and used by every ROB file.
package reorder_buffer_pkg;

    localparam int NUM_PHYSICAL_REGISTERS = 64;
    localparam int PW = $clog2(NUM_PHYSICAL_REGISTERS);
    localparam int AW = 5;

    typedef logic [AW-1:0] arch_reg_t;
    typedef logic [PW-1:0] phys_reg_t;

    typedef struct packed {
        logic      valid;
        logic      done;
        arch_reg_t rd;
        phys_reg_t p_rd;
        phys_reg_t p_old_rd;
    } rob_entry_t;

    function automatic logic [1:0] cnt2(input logic [1:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]};
    endfunction

    function automatic rob_entry_t new_entry(
        input arch_reg_t rd,
        input phys_reg_t p_rd,
        input phys_reg_t p_old_rd
    );
        rob_entry_t e;
        e.valid    = 1'b1;
        e.done     = 1'b0;
        e.rd       = rd;
        e.p_rd     = p_rd;
        e.p_old_rd = p_old_rd;
        return e;
    endfunction

    // An entry returns its old mapping only if it really renamed a register
    // and that old mapping is not the hard-wired physical register 0.
    function automatic logic frees_old(input rob_entry_t e);
        return (e.rd != '0) && (e.p_old_rd != '0);
    endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// reorder_buffer_if: rename-side allocate, writeback and retire bundle.
// slave = ROB view; master = upstream rename / writeback / free-pool view.
interface reorder_buffer_if #(
    parameter int DEPTH = 16
);
    import reorder_buffer_pkg::*;

    localparam int IW = $clog2(DEPTH);

    logic [1:0]                        alloc_valid;
    logic                              alloc_ready;
    arch_reg_t [1:0]                   alloc_rd;
    phys_reg_t [1:0]                   alloc_p_rd;
    phys_reg_t [1:0]                   alloc_p_old_rd;
    logic [1:0][IW-1:0]                alloc_idx;
    logic [1:0]                        wb_valid;
    logic [1:0][IW-1:0]                wb_idx;
    logic [1:0]                        commit_valid;
    arch_reg_t [1:0]                   commit_rd;
    phys_reg_t [1:0]                   commit_p_rd;
    logic [NUM_PHYSICAL_REGISTERS-1:0] free_mask;
    logic                              rob_empty;

    modport master (
        output alloc_valid, alloc_rd, alloc_p_rd, alloc_p_old_rd,
        output wb_valid, wb_idx,
        input  alloc_ready, alloc_idx,
        input  commit_valid, commit_rd, commit_p_rd,
        input  free_mask, rob_empty
    );

    modport slave (
        input  alloc_valid, alloc_rd, alloc_p_rd, alloc_p_old_rd,
        input  wb_valid, wb_idx,
        output alloc_ready, alloc_idx,
        output commit_valid, commit_rd, commit_p_rd,
        output free_mask, rob_empty
    );

endinterface

// File: rtl/reorder_buffer_retire_select.sv
// rob_retire_select: decides how many of the two oldest entries retire and
// builds their commit fields and freed-mapping mask (combinational).
module rob_retire_select
    import reorder_buffer_pkg::*;
(
    input  rob_entry_t                        head_i,
    input  rob_entry_t                        next_i,
    output logic [1:0]                        retire_o,
    output logic [1:0]                        nretire_o,
    output arch_reg_t [1:0]                   rd_o,
    output phys_reg_t [1:0]                   p_rd_o,
    output logic [NUM_PHYSICAL_REGISTERS-1:0] free_mask_o
);

    logic r0;
    logic r1;

    assign r0 = head_i.valid & head_i.done;
    // Younger slot may only retire behind the oldest one.
    assign r1 = r0 & next_i.valid & next_i.done;

    always_comb begin
        retire_o    = {r1, r0};
        nretire_o   = cnt2({r1, r0});
        rd_o        = '0;
        p_rd_o      = '0;
        free_mask_o = '0;
        if (r0) begin
            rd_o[0]   = head_i.rd;
            p_rd_o[0] = head_i.p_rd;
            if (frees_old(head_i)) begin
                free_mask_o[head_i.p_old_rd] = 1'b1;
            end
        end
        if (r1) begin
            rd_o[1]   = next_i.rd;
            p_rd_o[1] = next_i.p_rd;
            if (frees_old(next_i)) begin
                free_mask_o[next_i.p_old_rd] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// reorder_buffer: two-wide in-order retirement buffer behind rename.
// Ports: clk, rst_n (async low), bus (reorder_buffer_if.slave),
// flush (only when ROB_FLUSH_EN is defined: synchronous full clear).
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic clk,
    input  logic rst_n,
`ifdef ROB_FLUSH_EN
    input  logic flush,
`endif
    reorder_buffer_if.slave bus
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    typedef logic [IW-1:0] idx_t;
    typedef logic [CW-1:0] cnt_t;

    // Accept only with two free slots, judged on the pre-update count.
    localparam cnt_t ACCEPT_MAX = cnt_t'(DEPTH - 2);

    rob_entry_t ent_q [DEPTH];
    rob_entry_t ent_d [DEPTH];

    idx_t head_q;
    idx_t head_d;
    idx_t tail_q;
    idx_t tail_d;
    cnt_t count_q;
    cnt_t count_d;

    logic [1:0]                        cv_q;
    arch_reg_t [1:0]                   crd_q;
    phys_reg_t [1:0]                   cprd_q;
    logic [NUM_PHYSICAL_REGISTERS-1:0] fm_q;

    logic       ready;
    logic       fire;
    logic [1:0] nalloc;
    idx_t       head1;
    idx_t       tail1;
    logic       flush_w;

    logic [1:0]                        retire;
    logic [1:0]                        nretire;
    arch_reg_t [1:0]                   ret_rd;
    phys_reg_t [1:0]                   ret_p_rd;
    logic [NUM_PHYSICAL_REGISTERS-1:0] ret_mask;

`ifdef ROB_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    assign head1  = head_q + idx_t'(1);
    assign tail1  = tail_q + idx_t'(1);
    assign ready  = (count_q <= ACCEPT_MAX);
    assign fire   = bus.alloc_valid[0] & ready;
    assign nalloc = fire ? cnt2(bus.alloc_valid) : 2'd0;

    rob_retire_select u_sel (
        .head_i      (ent_q[head_q]),
        .next_i      (ent_q[head1]),
        .retire_o    (retire),
        .nretire_o   (nretire),
        .rd_o        (ret_rd),
        .p_rd_o      (ret_p_rd),
        .free_mask_o (ret_mask)
    );

    always_comb begin
        ent_d   = ent_q;
        head_d  = head_q + idx_t'(nretire);
        tail_d  = tail_q + idx_t'(nalloc);
        count_d = count_q + cnt_t'(nalloc) - cnt_t'(nretire);

        // Only entries already valid can complete, so a writeback racing
        // the allocation of its own index is dropped here.
        for (int p = 0; p < 2; p++) begin
            if (bus.wb_valid[p] && ent_q[bus.wb_idx[p]].valid) begin
                ent_d[bus.wb_idx[p]].done = 1'b1;
            end
        end

        if (retire[0]) begin
            ent_d[head_q] = '0;
        end
        if (retire[1]) begin
            ent_d[head1] = '0;
        end

        // Allocated slots are free, so they never collide with retirees.
        if (fire) begin
            ent_d[tail_q] = new_entry(bus.alloc_rd[0],
                                      bus.alloc_p_rd[0],
                                      bus.alloc_p_old_rd[0]);
            if (bus.alloc_valid[1]) begin
                ent_d[tail1] = new_entry(bus.alloc_rd[1],
                                         bus.alloc_p_rd[1],
                                         bus.alloc_p_old_rd[1]);
            end
        end

        if (flush_w) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_d[i] = '0;
            end
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            cv_q    <= '0;
            crd_q   <= '0;
            cprd_q  <= '0;
            fm_q    <= '0;
        end else begin
            ent_q   <= ent_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (flush_w) begin
                cv_q   <= '0;
                crd_q  <= '0;
                cprd_q <= '0;
                fm_q   <= '0;
            end else begin
                cv_q   <= retire;
                crd_q  <= ret_rd;
                cprd_q <= ret_p_rd;
                fm_q   <= ret_mask;
            end
        end
    end

    assign bus.alloc_ready  = ready;
    assign bus.alloc_idx[0] = tail_q;
    assign bus.alloc_idx[1] = tail1;
    assign bus.commit_valid = cv_q;
    assign bus.commit_rd    = crd_q;
    assign bus.commit_p_rd  = cprd_q;
    assign bus.free_mask    = fm_q;
    assign bus.rob_empty    = (count_q == '0);

endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed stimulus with a commit-order scoreboard.
// Flush scenario is built only when ROB_FLUSH_EN is defined.
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    localparam int DEPTH = 16;
    localparam int IW = $clog2(DEPTH);

    typedef struct {
        arch_reg_t rd;
        phys_reg_t prd;
        phys_reg_t pold;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
`ifdef ROB_FLUSH_EN
    logic flush = 1'b0;
`endif

    reorder_buffer_if #(.DEPTH(DEPTH)) bus ();

    reorder_buffer #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef ROB_FLUSH_EN
        .flush (flush),
`endif
        .bus   (bus)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   tail_m = 0;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        bus.alloc_valid    = '0;
        bus.alloc_rd       = '0;
        bus.alloc_p_rd     = '0;
        bus.alloc_p_old_rd = '0;
        bus.wb_valid       = '0;
        bus.wb_idx         = '0;
    endtask

    task automatic set_alloc(input int s, input int rd,
                             input int prd, input int pold);
        bus.alloc_valid[s]    = 1'b1;
        bus.alloc_rd[s]       = arch_reg_t'(rd);
        bus.alloc_p_rd[s]     = phys_reg_t'(prd);
        bus.alloc_p_old_rd[s] = phys_reg_t'(pold);
    endtask

    task automatic set_wb(input int p, input int idx);
        bus.wb_valid[p] = 1'b1;
        bus.wb_idx[p]   = IW'(idx);
    endtask

    // One clock: check/record any allocation offered, cross the edge.
    task automatic step(input bit accept);
        if (bus.alloc_valid[0]) begin
            check("alloc_ready", 64'(bus.alloc_ready), 64'(accept));
            check("alloc_idx0", 64'(bus.alloc_idx[0]), 64'(tail_m));
            if (bus.alloc_valid[1]) begin
                check("alloc_idx1", 64'(bus.alloc_idx[1]),
                      64'((tail_m + 1) % DEPTH));
            end
            if (accept) begin
                for (int s = 0; s < 2; s++) begin
                    if (bus.alloc_valid[s]) begin
                        sb.push_back('{bus.alloc_rd[s], bus.alloc_p_rd[s],
                                       bus.alloc_p_old_rd[s]});
                        tail_m = (tail_m + 1) % DEPTH;
                    end
                end
            end
        end
        @(negedge clk);
        idle();
    endtask

    logic [63:0] mon_mask;
    exp_t        mon_e;

    always @(negedge clk) begin
        if (rst_n) begin
            mon_mask = '0;
            check("cv_order", 64'(bus.commit_valid == 2'b10), 64'(0));
            for (int b = 0; b < 2; b++) begin
                if (bus.commit_valid[b]) begin
                    check("sb_under", 64'(sb.size() > 0), 64'(1));
                    if (sb.size() > 0) begin
                        mon_e = sb.pop_front();
                        check("c_rd", 64'(bus.commit_rd[b]), 64'(mon_e.rd));
                        check("c_prd", 64'(bus.commit_p_rd[b]),
                              64'(mon_e.prd));
                        if (mon_e.rd != 0 && mon_e.pold != 0) begin
                            mon_mask[mon_e.pold] = 1'b1;
                        end
                    end
                end
            end
            check("free_mask", bus.free_mask, mon_mask);
        end
    end

    task automatic reset_checks(input string tag);
        check({tag, "_empty"}, 64'(bus.rob_empty), 64'(1));
        check({tag, "_ready"}, 64'(bus.alloc_ready), 64'(1));
        check({tag, "_cv"}, 64'(bus.commit_valid), 64'(0));
        check({tag, "_fm"}, bus.free_mask, 64'(0));
    endtask

    task automatic pulse_reset(input string tag);
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        reset_checks(tag);
        @(negedge clk);
        rst_n = 1'b1;
        tail_m = 0;
    endtask

    initial begin
        idle();
        rst_n = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        reset_checks("rst0");
        check("rst0_idx", 64'(bus.alloc_idx[0]), 64'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // single flow
        set_alloc(0, 5, 33, 5);
        step(1);
        set_wb(0, 0);
        step(1);
        check("single_early", 64'(bus.commit_valid), 64'(0));
        step(1);
        check("single_cv", 64'(bus.commit_valid), 64'(2'b01));
        check("single_rd", 64'(bus.commit_rd[0]), 64'(5));
        check("single_prd", 64'(bus.commit_p_rd[0]), 64'(33));
        check("single_fm", bus.free_mask, 64'h20);
        step(1);
        check("single_pulse", 64'(bus.commit_valid), 64'(0));
        check("single_empty", 64'(bus.rob_empty), 64'(1));

        // reset in the middle of traffic
        set_alloc(0, 1, 10, 1);
        set_alloc(1, 2, 11, 2);
        step(1);
        set_alloc(0, 3, 12, 3);
        set_alloc(1, 4, 13, 4);
        set_wb(0, 1);
        set_wb(1, 2);
        step(1);
        set_alloc(0, 6, 14, 6);
        set_alloc(1, 7, 15, 7);
        step(1);
        check("pre_rst_cv", 64'(bus.commit_valid), 64'(2'b11));
        check("pre_rst_empty", 64'(bus.rob_empty), 64'(0));
        pulse_reset("rst_mid");

        // out-of-order completion
        set_alloc(0, 8, 20, 8);
        set_alloc(1, 9, 21, 9);
        step(1);
        set_alloc(0, 10, 22, 10);
        set_alloc(1, 11, 23, 11);
        step(1);
        set_wb(1, 3);
        step(1);
        check("ooo_h3", 64'(bus.commit_valid), 64'(0));
        set_wb(0, 2);
        set_wb(1, 2);
        step(1);
        check("ooo_h2", 64'(bus.commit_valid), 64'(0));
        set_wb(0, 1);
        step(1);
        check("ooo_h1", 64'(bus.commit_valid), 64'(0));
        set_wb(0, 0);
        step(1);
        check("ooo_h0", 64'(bus.commit_valid), 64'(0));
        step(1);
        check("ooo_c01", 64'(bus.commit_valid), 64'(2'b11));
        step(1);
        check("ooo_c23", 64'(bus.commit_valid), 64'(2'b11));
        step(1);
        check("ooo_end", 64'(bus.commit_valid), 64'(0));

        // rd=0 / p_old_rd=0 never free; same-cycle writeback is dropped
        set_alloc(0, 0, 40, 7);
        set_alloc(1, 3, 41, 0);
        set_wb(0, 4);
        step(1);
        step(1);
        check("wb_same_cyc", 64'(bus.commit_valid), 64'(0));
        set_wb(0, 4);
        set_wb(1, 5);
        step(1);
        step(1);
        check("zero_cv", 64'(bus.commit_valid), 64'(2'b11));
        check("zero_fm", bus.free_mask, 64'(0));

        // two retires freeing the same mapping share one bit
        set_alloc(0, 1, 42, 9);
        set_alloc(1, 2, 43, 9);
        step(1);
        set_wb(0, 6);
        set_wb(1, 7);
        step(1);
        step(1);
        check("dup_cv", 64'(bus.commit_valid), 64'(2'b11));
        check("dup_fm", bus.free_mask, 64'h200);
        step(1);

        // full buffer and wrap-around
        pulse_reset("rst_full");
        for (int k = 0; k < 7; k++) begin
            set_alloc(0, 2 * k + 1, 16 + 2 * k, 2 * k + 1);
            set_alloc(1, 2 * k + 2, 17 + 2 * k, 2 * k + 2);
            step(1);
        end
        check("rdy_at14", 64'(bus.alloc_ready), 64'(1));
        set_alloc(0, 15, 30, 15);
        step(1);
        check("rdy_at15", 64'(bus.alloc_ready), 64'(0));
        set_alloc(0, 20, 50, 20);
        set_alloc(1, 21, 51, 21);
        step(0);
        check("stall_idx", 64'(bus.alloc_idx[0]), 64'(tail_m));
        set_wb(0, 0);
        set_wb(1, 1);
        step(1);
        step(1);
        check("rdy_after_ret", 64'(bus.alloc_ready), 64'(1));
        set_alloc(0, 16, 31, 16);
        step(1);
        check("wrap_idx0", 64'(bus.alloc_idx[0]), 64'(0));
        check("wrap_idx1", 64'(bus.alloc_idx[1]), 64'(1));
        set_alloc(0, 17, 32, 17);
        set_alloc(1, 18, 34, 18);
        step(1);
        check("rdy_at16", 64'(bus.alloc_ready), 64'(0));
        for (int k = 0; k < 8; k++) begin
            set_wb(0, (2 + 2 * k) % DEPTH);
            set_wb(1, (3 + 2 * k) % DEPTH);
            step(1);
        end
        step(1);
        #1;
        check("drain_sb", 64'(sb.size()), 64'(0));
        check("drain_empty", 64'(bus.rob_empty), 64'(1));

`ifdef ROB_FLUSH_EN
        // flush with five entries pending, two of them done
        @(negedge clk);
        set_alloc(0, 1, 44, 11);
        set_alloc(1, 2, 45, 12);
        step(1);
        set_alloc(0, 3, 46, 13);
        set_alloc(1, 4, 47, 14);
        step(1);
        set_alloc(0, 5, 48, 15);
        step(1);
        set_wb(0, 2);
        set_wb(1, 3);
        step(1);
        flush = 1'b1;
        set_alloc(0, 6, 49, 16);
        set_wb(0, 4);
        step(1);
        flush = 1'b0;
        sb.delete();
        tail_m = 0;
        check("fl_cv", 64'(bus.commit_valid), 64'(0));
        check("fl_fm", bus.free_mask, 64'(0));
        check("fl_empty", 64'(bus.rob_empty), 64'(1));
        check("fl_idx", 64'(bus.alloc_idx[0]), 64'(0));
        step(1);
        check("fl_cv2", 64'(bus.commit_valid), 64'(0));
        set_alloc(0, 7, 52, 19);
        step(1);
        set_wb(0, 0);
        step(1);
        step(1);
        check("fl_after_cv", 64'(bus.commit_valid), 64'(2'b01));
        step(1);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
